adder_digit_serial: RTL

// - Parametrised multi-cycle N-bit adder; successor to the 4-bit ripple adder.
// - Adds DIGIT bits per clock, LSB digit first, through a chain of DIGIT fa_1b

---
 rtl/adder_digit_serial.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/adder_digit_serial.sv
// Digit-serial N-bit adder: DIGIT bits per cycle, LSB digit first, with a valid/ready handshake.
// Define ADDSUB_EN to add the Sub port (S = A - B, Cout = no-borrow).
module adder_digit_serial #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
`ifdef ADDSUB_EN
    input  logic             Sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);

    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned CntW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CntW-1:0] LastDig = CntW'(NDIG - 1);

    if ((DIGIT < 1) || (DIGIT > WIDTH) || (WIDTH % DIGIT != 0)) begin : gen_param_check
        $error("adder_digit_serial: WIDTH must be a non-zero multiple of DIGIT");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state;
    logic [WIDTH-1:0]  a_q, b_q, s_q, sum_q;
    logic              carry_q, cout_q, in_ready_q, out_valid_q;
    logic [CntW-1:0]   cnt_q;

    logic              sub_in;
    logic [WIDTH-1:0]  b_load;
    logic              c_load;
    logic [DIGIT-1:0]  dig_sum;
    logic [DIGIT:0]    chain;
    logic [WIDTH-1:0]  s_shift;

`ifdef ADDSUB_EN
    assign sub_in = Sub;
`else
    assign sub_in = 1'b0;
`endif

    // Subtract as A + ~B + 1; Cin is ignored when subtracting.
    assign b_load = B ^ {WIDTH{sub_in}};
    assign c_load = sub_in | Cin;

    assign chain[0] = carry_q;
    for (genvar i = 0; i < DIGIT; i++) begin : gen_fa
        fa_1b u_fa (
            .a   (a_q[i]),
            .b   (b_q[i]),
            .cin (chain[i]),
            .s   (dig_sum[i]),
            .cout(chain[i+1])
        );
    end

    // Sum digits enter from the MSB side so the last digit lands at the top.
    if (DIGIT == WIDTH) begin : gen_shift_full
        assign s_shift = dig_sum;
    end else begin : gen_shift_part
        assign s_shift = {dig_sum, s_q[WIDTH-1:DIGIT]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StIdle;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            s_q         <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (in_valid) begin
                        a_q        <= A;
                        b_q        <= b_load;
                        carry_q    <= c_load;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state      <= StRun;
                    end
                end
                StRun: begin
                    a_q     <= a_q >> DIGIT;
                    b_q     <= b_q >> DIGIT;
                    s_q     <= s_shift;
                    carry_q <= chain[DIGIT];
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LastDig) begin
                        sum_q       <= s_shift;
                        cout_q      <= chain[DIGIT];
                        out_valid_q <= 1'b1;
                        state       <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= StIdle;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state       <= StIdle;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign S         = sum_q;
    assign Cout      = cout_q;

endmodule

// One-bit full adder used as the digit slice.
module fa_1b (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule
